// File: rtl/poly_small_sqnorm_chk.sv
// Squared-norm and coefficient range checker for the sampled Falcon (f,g) pair.
// Optional define POLY_SMALL_SQNORM_DBG_EN adds the sqnorm output holding the final norm.
module poly_small_sqnorm_chk #(
  parameter int logn = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        f_valid,
  input  logic [7:0]  f,
`ifdef POLY_SMALL_SQNORM_DBG_EN
  output logic [25:0] sqnorm,
`endif
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        range_err
);

  // Coefficient bound 1 << (max_fg_bits[logn] - 1) from the Falcon table.
  function automatic int fg_lim(input int lg);
    case (lg)
      6, 7:    return 64;
      8, 9:    return 32;
      10:      return 16;
      default: return 128;
    endcase
  endfunction

  localparam int LIM = fg_lim(logn);

  typedef enum logic [2:0] {IDLE, ACC_F, ACC_G, FLUSH, FIN} state_t;

  // Handshake: a coefficient is consumed on any cycle with f_valid=1 while the
  // FSM is in ACC_F or ACC_G; there is no back-pressure, strobes elsewhere are dropped.
  state_t            state;
  logic [logn-1:0]   cnt;
  logic [14:0]       sq_q;
  logic              sq_v;
  logic [25:0]       acc;

  logic              take;
  logic              cnt_last;
  logic              oor;
  logic [7:0]        mag;
  logic [14:0]       sq_next;
  logic [25:0]       final_sum;
  int                f_int;

  always_comb begin
    take      = f_valid && ((state == ACC_F) || (state == ACC_G));
    cnt_last  = (cnt == {logn{1'b1}});
    f_int     = int'($signed(f));
    oor       = (f_int >= LIM) || (f_int <= -LIM);
    mag       = f[7] ? (8'd0 - f) : f;
    sq_next   = 15'({7'd0, mag} * {7'd0, mag});
    final_sum = acc + (sq_v ? {11'd0, sq_q} : 26'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sq_q      <= '0;
      sq_v      <= 1'b0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      range_err <= 1'b0;
`ifdef POLY_SMALL_SQNORM_DBG_EN
      sqnorm    <= '0;
`endif
    end else begin
      done <= 1'b0;
      sq_v <= take;
      if (take) sq_q <= sq_next;
      if (sq_v) acc <= final_sum;
      case (state)
        IDLE: begin
          if (ena) begin
            cnt       <= '0;
            acc       <= '0;
            sq_v      <= 1'b0;
            range_err <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
`ifdef POLY_SMALL_SQNORM_DBG_EN
            sqnorm    <= '0;
`endif
            state     <= ACC_F;
          end
        end
        ACC_F, ACC_G: begin
          if (take) begin
            if (oor) range_err <= 1'b1;
            cnt <= cnt + logn'(1);
            if (cnt_last) state <= (state == ACC_F) ? ACC_G : FLUSH;
          end
        end
        FLUSH: begin
          // The last square is still in sq_q here, so the verdict uses the drained sum.
          pass  <= (final_sum < 26'd16823) && !range_err;
          done  <= 1'b1;
          busy  <= 1'b0;
`ifdef POLY_SMALL_SQNORM_DBG_EN
          sqnorm <= final_sum;
`endif
          state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_small_sqnorm_chk.sv
// Directed bench for poly_small_sqnorm_chk: one logn=9 and one logn=10 instance.
module tb_poly_small_sqnorm_chk;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] f = '0;
  logic ena_a = 1'b0, f_valid_a = 1'b0, ena_b = 1'b0, f_valid_b = 1'b0;
  logic busy_a, done_a, pass_a, range_err_a;
  logic busy_b, done_b, pass_b, range_err_b;
`ifdef POLY_SMALL_SQNORM_DBG_EN
  logic [25:0] sqnorm_a, sqnorm_b;
`endif
  logic sel = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  poly_small_sqnorm_chk #(.logn(9)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .f_valid(f_valid_a), .f(f),
`ifdef POLY_SMALL_SQNORM_DBG_EN
    .sqnorm(sqnorm_a),
`endif
    .busy(busy_a), .done(done_a), .pass(pass_a), .range_err(range_err_a)
  );

  poly_small_sqnorm_chk #(.logn(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .f_valid(f_valid_b), .f(f),
`ifdef POLY_SMALL_SQNORM_DBG_EN
    .sqnorm(sqnorm_b),
`endif
    .busy(busy_b), .done(done_b), .pass(pass_b), .range_err(range_err_b)
  );

  logic obs_busy, obs_done, obs_pass, obs_rerr;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_done = sel ? done_b : done_a;
  assign obs_pass = sel ? pass_b : pass_a;
  assign obs_rerr = sel ? range_err_b : range_err_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Stimulus pattern per mode; idx runs over f then g (g starts at nn).
  function automatic logic [7:0] coef(input int mode, input int idx, input int nn);
    case (mode)
      1: return (idx % 2 == 0) ? 8'd4 : 8'hFC;
      2: return 8'd5;
      3: return (idx == nn + 10) ? 8'hE0 : 8'd0;
      4: return (idx == 7) ? 8'd15 : 8'd0;
      5: return (idx == 7) ? 8'd16 : 8'd0;
      6: return (idx == 3) ? 8'd31 : 8'd0;
      7, 8: begin
        if (idx < 17) return 8'd31;
        if (idx == 17) return 8'd22;
        if (idx == 18) return 8'd1;
        if (idx == 19 && mode == 8) return 8'd1;
        return 8'd0;
      end
      default: return 8'd0;
    endcase
  endfunction

  // Hand-computed results per mode: {sqnorm, pass, range_err}.
  function automatic int exp_sq(input int mode);
    case (mode)
      1: return 16384;
      2: return 25600;
      3: return 1024;
      4: return 225;
      5: return 256;
      6: return 961;
      7: return 16822;
      8: return 16823;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_pass(input int mode);
    return (mode == 0) || (mode == 1) || (mode == 4) || (mode == 6) || (mode == 7);
  endfunction

  function automatic logic exp_rerr(input int mode);
    return (mode == 3) || (mode == 5);
  endfunction

  task automatic run(input bit big, input int mode, input bit gaps, input int ena_at, input int rst_at);
    int nn;
    nn = big ? 1024 : 512;
    sel = big;
    if (big) ena_b = 1'b1; else ena_a = 1'b1;
    @(posedge clk); #1;
    ena_a = 1'b0; ena_b = 1'b0;
    check($sformatf("busy_start_m%0d", mode), 32'(obs_busy), 32'd1);
    for (int i = 0; i < 2 * nn; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(obs_busy), 32'd0);
        check("rst_done", 32'(obs_done), 32'd0);
        check("rst_pass", 32'(obs_pass), 32'd0);
        check("rst_rerr", 32'(obs_rerr), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      f = coef(mode, i, nn);
      if (big) f_valid_b = 1'b1; else f_valid_a = 1'b1;
      if (i == ena_at) begin
        if (big) ena_b = 1'b1; else ena_a = 1'b1;
      end
      @(posedge clk); #1;
      f_valid_a = 1'b0; f_valid_b = 1'b0; ena_a = 1'b0; ena_b = 1'b0;
      if (i == ena_at) check("busy_mid_ena", 32'(obs_busy), 32'd1);
    end
    check($sformatf("flush_done_m%0d", mode), 32'(obs_done), 32'd0);
    check($sformatf("flush_busy_m%0d", mode), 32'(obs_busy), 32'd1);
    @(posedge clk); #1;
    check($sformatf("done_m%0d", mode), 32'(obs_done), 32'd1);
    check($sformatf("busy_fin_m%0d", mode), 32'(obs_busy), 32'd0);
    check($sformatf("pass_m%0d", mode), 32'(obs_pass), 32'(exp_pass(mode)));
    check($sformatf("rerr_m%0d", mode), 32'(obs_rerr), 32'(exp_rerr(mode)));
`ifdef POLY_SMALL_SQNORM_DBG_EN
    check($sformatf("sqnorm_m%0d", mode), 32'(sel ? sqnorm_b : sqnorm_a), 32'(exp_sq(mode)));
`else
    if (exp_sq(mode) < 0) check("sq_neg", 32'd0, 32'd1);
`endif
    @(posedge clk); #1;
    check($sformatf("done_drop_m%0d", mode), 32'(obs_done), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_done", 32'(done_a), 32'd0);
    check("reset_pass", 32'(pass_a), 32'd0);
    check("reset_rerr", 32'(range_err_a), 32'd0);
`ifdef POLY_SMALL_SQNORM_DBG_EN
    check("reset_sqnorm", 32'(sqnorm_a), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(1'b0, 0, 1'b0, -1, -1);
    run(1'b0, 1, 1'b0, -1, -1);
    run(1'b0, 2, 1'b0, -1, -1);
    run(1'b0, 3, 1'b0, -1, -1);
    run(1'b0, 6, 1'b0, -1, -1);
    run(1'b0, 7, 1'b0, -1, -1);
    run(1'b0, 8, 1'b0, -1, -1);
    run(1'b1, 4, 1'b0, -1, -1);
    run(1'b1, 5, 1'b0, -1, -1);

    // Gapped run with a stray ena must still finish on the original count.
    run(1'b0, 0, 1'b1, 200, -1);
    // Gapped run aborted by reset at coefficient 300.
    run(1'b0, 3, 1'b1, 100, 300);

    // Strobes while idle must not disturb the next run.
    sel = 1'b0;
    f = 8'd127;
    f_valid_a = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    f_valid_a = 1'b0;
    check("idle_strobe_busy", 32'(busy_a), 32'd0);
    check("idle_strobe_rerr", 32'(range_err_a), 32'd0);
    run(1'b0, 0, 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/poly_small_sqnorm_chk.md
# poly_small_sqnorm_chk

Downstream consumer of the small-Gaussian polynomial sampler in the Falcon key-generation datapath. It ingests the sampler's signed 8-bit coefficient stream for f and then g (2n coefficients total), range-checks each coefficient against the Falcon max_fg_bits limit, and accumulates the squared norm of (f,g). It issues a one-shot accept/reject verdict (norm < 16823 and all coefficients in range) so the keygen controller can restart sampling on rejection.

## Interface
- logn, 9, log2 of ring degree (9 = Falcon-512, 10 = Falcon-1024); n = 1 << logn
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  start pulse; arms the block for a new (f,g) pair
- f_valid  input  1  coefficient strobe from the sampler
- f  input  8  signed coefficient, valid when f_valid=1
- busy  output  1  high from accepted ena until done
- done  output  1  one-cycle pulse: verdict available
- pass  output  1  verdict: 1 = accept; held until next accepted ena
- range_err  output  1  sticky: some coefficient out of range; held until next accepted ena

## Operation
- States: IDLE, ACC_F, ACC_G, FLUSH, FIN.
- IDLE: ena=1 -> clear coefficient counter, accumulator, range_err, pass; go ACC_F; busy=1.
- ACC_F: each f_valid=1 counts one coefficient; after the n-th go ACC_G, counter cleared.
- ACC_G: same; after the n-th go FLUSH.
- FLUSH: one cycle draining the square pipeline register; go FIN.
- FIN: compute pass = (acc < 16823) && !range_err; done=1 for this cycle; busy=0; go IDLE.
- Range limit lim = 32 for logn=9, 16 for logn=10; a coefficient with f >= lim or f <= -lim sets range_err. Any other logn: lim = 1 << (max_fg_bits[logn] - 1), per the Falcon max_fg_bits table.
- Arithmetic: |f| <= 128, square is a 15-bit unsigned; accumulator is 26-bit unsigned; 2048*16384 = 2^25, so no overflow and no saturation.
- Counter is logn bits wide and wraps to 0 on the n-th coefficient of each phase.
- f_valid in IDLE, FLUSH, or FIN: ignored, with no effect on state or accumulator.
- ena while busy: ignored; the current run continues.
- f_valid may have arbitrary gaps; only strobed cycles count.
- Reset at any time: all state returns to IDLE, all outputs go to 0, and any partial run is discarded.

## Timing
- Reset values: busy=0, done=0, pass=0, range_err=0 (and sqnorm=0 when present).
- busy rises the cycle after ena is sampled in IDLE.
- Square stage is registered: a coefficient is squared in the cycle after f_valid and added in the next cycle.
- Last g coefficient sampled at cycle t -> FLUSH at t+1, done pulse and pass valid at t+2.
- busy falls in the same cycle done rises.
- range_err updates the cycle after the offending coefficient is sampled.
- A new ena may be accepted in the cycle after done.

## Configuration
- POLY_SMALL_SQNORM_DBG_EN
  - Defined: adds output port sqnorm [25:0], loaded with the final accumulator value at FIN and held until the next accepted ena.
  - Undefined: port and holding register are absent; verdict behaviour is identical.

## Test plan
- logn=9, ena, then 1024 zero coefficients back-to-back -> done 2 cycles after the last strobe; pass=1, range_err=0, sqnorm=0.
- logn=9, 1024 coefficients alternating +4/-4 -> sqnorm=16384, pass=1.
- logn=9, 1024 coefficients of +5 -> sqnorm=25600, pass=0, range_err=0.
- logn=9, all zeros except one g coefficient = -32 -> range_err=1, pass=0, sqnorm=1024.
- logn=10, one coefficient = 15 (others 0) -> pass=1; rerun with 16 -> range_err=1, pass=0.
- logn=9, random f_valid gaps; ena re-pulsed mid-run; rst_n asserted at coefficient 300, then a clean run of zeros -> mid-run ena ignored, reset clears busy/pass immediately, clean run gives pass=1.
